transfer_controller: RTL and testbench
======================================

TRANSFER_CONTROLLER -- requirements
Module: transfer_controller

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have the port req, input, 2 bits: per-requester request; bit 0 is the pipeline, bit 1 is the bus master.
REQ-004 The block SHALL have the ports op0 and op1, input, 2 bits each: operation code for requesters 0 and 1.
REQ-005 The block SHALL have the port gnt, output, 2 bits: one-hot grant, held from the first step cycle through the DONE cycle.
REQ-006 The block SHALL have the ports busy and done, output, 1 bit each: busy means an operation is in progress; done is a one-cycle completion pulse.
REQ-007 The block SHALL have the ports l_tl, l_th, l_tx, output, 1 bit each, active-high: load strobes to the transfer register.
REQ-008 The block SHALL have the ports a_tl, a_th, a_tx_addr, a_tx_xfer, a_tx_mode, output, 1 bit each, active-high: bus-drive enables to the transfer register.

Function
REQ-009 The block SHALL implement the states IDLE, STEP1, STEP2 and DONE in a registered state machine, and all outputs SHALL be decoded from registered state only.
REQ-010 In IDLE with req != 0, the block SHALL latch the winner's op and grant index, and SHALL enter STEP1 on the next edge.
REQ-011 The block SHALL sequence STEP1 -> STEP2 -> DONE -> IDLE unconditionally, one cycle each.
REQ-012 The block SHALL fix request-to-done latency at 3 cycles (req seen in IDLE at cycle N, done at N+3) and SHALL fix minimum request spacing at 4 cycles.
REQ-013 For op 00 (LDW), the block SHALL assert l_tl in STEP1 and l_th in STEP2.
REQ-014 For op 01 (STW), the block SHALL assert a_tl in STEP1 and a_th in STEP2.
REQ-015 For op 10 (XFER), the block SHALL assert l_tx in STEP1 and a_tx_xfer in STEP2.
REQ-016 For op 11 (ADDR), the block SHALL assert l_tx in STEP1 and both a_tx_addr and a_tx_mode in STEP2.
REQ-017 All strobes and enables SHALL be 0 in IDLE and DONE.
REQ-018 At most one of a_tl, a_th, a_tx_addr, a_tx_xfer SHALL be 1 in any cycle.
REQ-019 The block SHALL set busy=1 in STEP1, STEP2 and DONE, and busy=0 in IDLE.
REQ-020 The block SHALL set gnt to the latched one-hot value while busy, and to 00 otherwise.
REQ-021 Changes to req or op after the IDLE sampling edge SHALL be ignored until the next IDLE; the operation completes even if req drops.
REQ-022 The block SHALL re-arbitrate a request still asserted at DONE in the following IDLE cycle; the requester deasserts req in response to done.
REQ-023 When both requests are set in IDLE, the arbitration rule in REQ-026/027 SHALL decide the winner; the loser waits with no timeout.

Reset
REQ-024 When reset=1 on a clock edge, the block SHALL force IDLE, with gnt=00, busy=0, done=0, all strobes/enables 0, latched op=00, and RR pointer=0, even in the middle of an operation.
REQ-025 An operation interrupted by reset SHALL NOT produce done, and a request present in the first cycle after reset deassertion SHALL be serviced normally.

Configuration
REQ-026 When macro XFER_RR_ARB_EN is defined, the block SHALL use round-robin arbitration: a 1-bit pointer names the preferred requester, and it is set to the other index at each DONE.
REQ-027 When XFER_RR_ARB_EN is undefined, the block SHALL use fixed priority (req[0] always wins) and SHALL contain no pointer register.

Verification
REQ-028 The bench SHALL cover: req=01, op0=00 at cycle 0 -> gnt=01 and l_tl=1 at cycle 1, l_th=1 at cycle 2, done=1 at cycle 3, busy=0 at cycle 4.
REQ-029 The bench SHALL cover: req=10, op1=11 -> l_tx=1 at cycle 1, a_tx_addr=a_tx_mode=1 at cycle 2, with no other enables set.
REQ-030 The bench SHALL cover: req=11 held, op0=01, op1=10 for 3 operations -> fixed priority gives grants 01,01,01; with XFER_RR_ARB_EN grants are 01,10,01.
REQ-031 The bench SHALL cover: req=01, op0=01 with reset=1 at cycle 2 -> at cycle 3 all outputs are 0, busy=0, and done is never pulsed.
REQ-032 The bench SHALL cover: req dropped at cycle 1 during XFER -> a_tx_xfer=1 at cycle 2 and done=1 at cycle 3 regardless.
REQ-033 The bench SHALL cover: random req/op for 10k cycles -> no cycle has two drive enables active, and gnt is always one-hot or 00.

Source files
------------

// File: rtl/transfer_controller.sv
// transfer_controller: two-requester arbiter that sequences a fixed
// two-step load/drive pattern onto a transfer register.
// Optional feature: define XFER_RR_ARB_EN for round-robin arbitration;
// without it, requester 0 always wins a tie.
module transfer_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [1:0] op0,
    input  logic [1:0] op1,
    output logic [1:0] gnt,
    output logic       busy,
    output logic       done,
    output logic       l_tl,
    output logic       l_th,
    output logic       l_tx,
    output logic       a_tl,
    output logic       a_th,
    output logic       a_tx_addr,
    output logic       a_tx_xfer,
    output logic       a_tx_mode
);

    localparam int unsigned OP_W = 2;

    localparam logic [OP_W-1:0] OP_LDW  = 2'b00;
    localparam logic [OP_W-1:0] OP_STW  = 2'b01;
    localparam logic [OP_W-1:0] OP_XFER = 2'b10;
    localparam logic [OP_W-1:0] OP_ADDR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        STEP1 = 2'b01,
        STEP2 = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t          state_q;
    logic [OP_W-1:0] op_q;
    logic            win_idx_d;
    logic [OP_W-1:0] win_op_d;

`ifdef XFER_RR_ARB_EN
    logic            ptr_q;
`endif

    // Pick the winning requester and its op from the live request lines.
    always_comb begin
        win_idx_d = 1'b0;
        if (req == 2'b10) begin
            win_idx_d = 1'b1;
        end
`ifdef XFER_RR_ARB_EN
        else if (req == 2'b11) begin
            win_idx_d = ptr_q;
        end
`endif
        win_op_d = win_idx_d ? op1 : op0;
    end

    // Sequencer: state plus every output registered together, so each
    // output is a pure function of the registered state and latched op.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= OP_LDW;
            gnt       <= 2'b00;
            busy      <= 1'b0;
            done      <= 1'b0;
            l_tl      <= 1'b0;
            l_th      <= 1'b0;
            l_tx      <= 1'b0;
            a_tl      <= 1'b0;
            a_th      <= 1'b0;
            a_tx_addr <= 1'b0;
            a_tx_xfer <= 1'b0;
            a_tx_mode <= 1'b0;
`ifdef XFER_RR_ARB_EN
            ptr_q     <= 1'b0;
`endif
        end else begin
            done      <= 1'b0;
            l_tl      <= 1'b0;
            l_th      <= 1'b0;
            l_tx      <= 1'b0;
            a_tl      <= 1'b0;
            a_th      <= 1'b0;
            a_tx_addr <= 1'b0;
            a_tx_xfer <= 1'b0;
            a_tx_mode <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        state_q <= STEP1;
                        op_q    <= win_op_d;
                        gnt     <= win_idx_d ? 2'b10 : 2'b01;
                        busy    <= 1'b1;
                        case (win_op_d)
                            OP_LDW:  l_tl <= 1'b1;
                            OP_STW:  a_tl <= 1'b1;
                            default: l_tx <= 1'b1;
                        endcase
                    end
                end
                STEP1: begin
                    state_q <= STEP2;
                    case (op_q)
                        OP_LDW:  l_th      <= 1'b1;
                        OP_STW:  a_th      <= 1'b1;
                        OP_XFER: a_tx_xfer <= 1'b1;
                        OP_ADDR: begin
                            a_tx_addr <= 1'b1;
                            a_tx_mode <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                STEP2: begin
                    state_q <= DONE;
                    done    <= 1'b1;
                end
                DONE: begin
                    state_q <= IDLE;
                    gnt     <= 2'b00;
                    busy    <= 1'b0;
`ifdef XFER_RR_ARB_EN
                    // Prefer the requester that was not just served.
                    ptr_q   <= gnt[0];
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_transfer_controller.sv
// Directed and randomized self-checking bench for transfer_controller.
module tb_transfer_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req;
    logic [1:0] op0;
    logic [1:0] op1;
    logic [1:0] gnt;
    logic       busy, done;
    logic       l_tl, l_th, l_tx;
    logic       a_tl, a_th, a_tx_addr, a_tx_xfer, a_tx_mode;

    int checks   = 0;
    int failures = 0;

    transfer_controller dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .op0       (op0),
        .op1       (op1),
        .gnt       (gnt),
        .busy      (busy),
        .done      (done),
        .l_tl      (l_tl),
        .l_th      (l_th),
        .l_tx      (l_tx),
        .a_tl      (a_tl),
        .a_th      (a_th),
        .a_tx_addr (a_tx_addr),
        .a_tx_xfer (a_tx_xfer),
        .a_tx_mode (a_tx_mode)
    );

    always #5 clk = ~clk;

    // {gnt[1:0], busy, done, l_tl, l_th, l_tx, a_tl, a_th, a_tx_addr, a_tx_xfer, a_tx_mode}
    logic [11:0] outv;
    assign outv = {gnt, busy, done, l_tl, l_th, l_tx, a_tl, a_th, a_tx_addr, a_tx_xfer, a_tx_mode};

    // Reference model state for the random phase.
    int unsigned m_st;
    logic        m_idx;
    logic [1:0]  m_op;
    logic        m_ptr;
    logic [11:0] m_exp;
    logic        m_rr;

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] model_out(input int unsigned st, input logic idx, input logic [1:0] op);
        logic [11:0] v;
        logic s1, s2;
        v = '0;
        s1 = (st == 1);
        s2 = (st == 2);
        if (st != 0) begin
            v[11:10] = idx ? 2'b10 : 2'b01;
            v[9] = 1'b1;
        end
        v[8] = (st == 3);
        v[7] = s1 && op == 2'b00;
        v[6] = s2 && op == 2'b00;
        v[5] = s1 && op[1];
        v[4] = s1 && op == 2'b01;
        v[3] = s2 && op == 2'b01;
        v[2] = s2 && op == 2'b11;
        v[1] = s2 && op == 2'b10;
        v[0] = s2 && op == 2'b11;
        return v;
    endfunction

    initial begin
        logic [1:0] g_second;
        logic [11:0] step1_second;
`ifdef XFER_RR_ARB_EN
        m_rr = 1'b1;
        g_second = 2'b10;
        step1_second = 12'b10_1_0_0_0_1_0_0_0_0_0;
`else
        m_rr = 1'b0;
        g_second = 2'b01;
        step1_second = 12'b01_1_0_0_0_0_1_0_0_0_0;
`endif
        reset = 1'b1; req = 2'b00; op0 = 2'b00; op1 = 2'b00;
        step(); step();
        chk("reset_state", outv, 12'h000);
        reset = 1'b0;
        step();
        chk("idle_no_req", outv, 12'h000);

        // LDW from requester 0
        req = 2'b01; op0 = 2'b00;
        step();
        req = 2'b00;
        chk("ldw_c1", outv, 12'b01_1_0_1_0_0_0_0_0_0_0);
        step();
        chk("ldw_c2", outv, 12'b01_1_0_0_1_0_0_0_0_0_0);
        step();
        chk("ldw_c3_done", outv, 12'b01_1_1_0_0_0_0_0_0_0_0);
        step();
        chk("ldw_c4_idle", outv, 12'h000);

        // ADDR from requester 1
        req = 2'b10; op1 = 2'b11;
        step();
        req = 2'b00;
        chk("addr_c1", outv, 12'b10_1_0_0_0_1_0_0_0_0_0);
        step();
        chk("addr_c2", outv, 12'b10_1_0_0_0_0_0_0_1_0_1);
        step();
        chk("addr_c3_done", outv, 12'b10_1_1_0_0_0_0_0_0_0_0);
        step();
        chk("addr_c4_idle", outv, 12'h000);

        // Contention: both held for three operations, starting from reset pointer
        reset = 1'b1;
        step();
        reset = 1'b0;
        req = 2'b11; op0 = 2'b01; op1 = 2'b10;
        step();
        chk("arb_op1_step1", outv, 12'b01_1_0_0_0_0_1_0_0_0_0);
        step(); step();
        chk("arb_op1_done", outv, 12'b01_1_1_0_0_0_0_0_0_0_0);
        step();
        chk("arb_rearb_idle", outv, 12'h000);
        step();
        chk("arb_op2_step1", outv, step1_second);
        step(); step(); step(); step();
        chk("arb_op3_step1", outv, 12'b01_1_0_0_0_0_1_0_0_0_0);
        chk("arb_op2_gnt", {10'd0, g_second}, {10'd0, step1_second[11:10]});
        req = 2'b00;
        step(); step(); step();
        chk("arb_end_idle", outv, 12'h000);

        // Reset in the middle of an STW
        req = 2'b01; op0 = 2'b01;
        step();
        req = 2'b00;
        chk("rst_stw_c1", outv, 12'b01_1_0_0_0_0_1_0_0_0_0);
        step();
        chk("rst_stw_c2", outv, 12'b01_1_0_0_0_0_0_1_0_0_0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_c3_cleared", outv, 12'h000);
        req = 2'b01; op0 = 2'b00;
        step();
        req = 2'b00;
        chk("post_rst_c4_serviced", outv, 12'b01_1_0_1_0_0_0_0_0_0_0);
        step();
        chk("post_rst_c5_no_done", outv, 12'b01_1_0_0_1_0_0_0_0_0_0);
        step();
        chk("post_rst_c6_done", outv, 12'b01_1_1_0_0_0_0_0_0_0_0);
        step();

        // XFER with req dropped after the sampling edge
        req = 2'b01; op0 = 2'b10;
        step();
        req = 2'b00; op0 = 2'b11;
        chk("xfer_c1", outv, 12'b01_1_0_0_0_1_0_0_0_0_0);
        step();
        chk("xfer_c2", outv, 12'b01_1_0_0_0_0_0_0_0_1_0);
        step();
        chk("xfer_c3_done", outv, 12'b01_1_1_0_0_0_0_0_0_0_0);
        step();
        chk("xfer_c4_idle", outv, 12'h000);

        // Random traffic against the reference model
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_st = 0; m_idx = 1'b0; m_op = 2'b00; m_ptr = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            req = 2'($urandom_range(0, 3));
            op0 = 2'($urandom_range(0, 3));
            op1 = 2'($urandom_range(0, 3));
            reset = ($urandom_range(0, 199) == 0);
            if (reset) begin
                m_st = 0; m_idx = 1'b0; m_op = 2'b00; m_ptr = 1'b0;
            end else begin
                case (m_st)
                    0: if (req != 2'b00) begin
                        if (req == 2'b10) m_idx = 1'b1;
                        else if (req == 2'b11 && m_rr) m_idx = m_ptr;
                        else m_idx = 1'b0;
                        m_op = m_idx ? op1 : op0;
                        m_st = 1;
                    end
                    1: m_st = 2;
                    2: m_st = 3;
                    default: begin
                        m_st = 0;
                        m_ptr = ~m_idx;
                    end
                endcase
            end
            step();
            reset = 1'b0;
            m_exp = model_out(m_st, m_idx, m_op);
            chk("rand_outputs", outv, m_exp);
            chk("rand_drive_onehot0", {11'd0, $countones({a_tl, a_th, a_tx_addr, a_tx_xfer}) <= 1}, 12'd1);
            chk("rand_gnt_onehot0", {11'd0, (gnt != 2'b11)}, 12'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
